mem_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus: the RAM plus memory-mapped I/O slave that the CPU's mem_a/mem_dout/mem_wr/mem_din/io_buffer_full interface talks to.
- Provides 128 KB single-port byte RAM with 1-cycle read latency.
- Provides the 0x30000 (UART byte) and 0x30004 (cycle counter / program stop) I/O registers, with TX/RX FIFOs toward a UART.
- Sits at the top level between cpu and the UART/host interface.

---
 rtl/mem_io_pkg.sv | 19 +
 rtl/mem_io_responder_if.sv | 11 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/mem_io_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_io_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU-side memory/I-O responder: I/O register map and FSM encodings.
package mem_io_pkg;

    localparam logic [17:0] IO_UART      = 18'h30000;
    localparam logic [17:0] IO_CLK       = 18'h30004;
    localparam logic [17:0] IO_STAT_SENT = 18'h30008;
    localparam logic [17:0] IO_STAT_DROP = 18'h3000C;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] RUN          = 2'd0;
    localparam logic [STATE_W-1:0] HALT_PENDING = 2'd1;
    localparam logic [STATE_W-1:0] HALTED       = 2'd2;

    // Little-endian byte lane of a 32-bit word
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        return 8'(w >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus between the cpu (master) and mem_io_responder (slave).
interface mem_io_responder_if;
    logic [17:0] mem_a;
    logic        mem_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;

    modport master (output mem_a, mem_wr, cpu_dout, input cpu_din, io_buffer_full);
    modport slave  (input mem_a, mem_wr, cpu_dout, output cpu_din, io_buffer_full);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// RAM plus memory-mapped UART / cycle-counter slave for the CPU byte bus.
// Optional MEM_IO_STATS_EN adds TX-sent and drop counters at 0x30008..0x3000F.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_FIFO_DEPTH  = 16,
    parameter int unsigned RX_FIFO_DEPTH  = 16,
    parameter int unsigned FULL_MARGIN    = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    mem_io_responder_if.slave bus,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             program_finished
);
    localparam int unsigned TX_CW     = $clog2(TX_FIFO_DEPTH) + 1;
    localparam int unsigned RX_CW     = $clog2(RX_FIFO_DEPTH) + 1;
    localparam int unsigned RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;

    logic [7:0]                ram [RAM_DEPTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      is_io, io_rd, io_wr, ram_wr, uart_wr_c, clk_wr_c;
    logic [STATE_W-1:0]        state, state_nxt;
    logic                      zero_pend, zero_pend_nxt, finished_nxt;
    logic                      tx_push_c, tx_pop_c, tx_space_c, tx_full, tx_empty;
    logic [7:0]                tx_din_c;
    logic [TX_CW-1:0]          tx_count, tx_cnt_nxt;
    logic                      rx_pop_c, rx_pop_ok_c, rx_push_c, rx_full, rx_empty;
    logic [RX_CW-1:0]          rx_count;
    logic [7:0]                rx_head, io_rdata_c;
    logic [31:0]               cycle_cnt, snapshot;

    assign ram_idx   = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign is_io     = (bus.mem_a[17:16] == 2'b11);
    assign io_rd     = is_io && !bus.mem_wr;
    assign io_wr     = is_io && bus.mem_wr;
    assign ram_wr    = !is_io && bus.mem_wr;
    assign uart_wr_c = io_wr && (bus.mem_a == IO_UART) && (bus.cpu_dout != 8'h00);
    assign clk_wr_c  = io_wr && (bus.mem_a == IO_CLK);

    assign tx_valid   = !tx_empty;
    assign tx_pop_c   = tx_valid && tx_ready;
    assign tx_space_c = !tx_full || tx_pop_c;
    assign tx_cnt_nxt = tx_count + TX_CW'(tx_push_c) - TX_CW'(tx_pop_c);

    assign rx_pop_c    = io_rd && (bus.mem_a == IO_UART);
    assign rx_pop_ok_c = rx_pop_c && !rx_empty;
    assign rx_push_c   = rx_valid && (!rx_full || rx_pop_ok_c);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk(clk_in), .rst(rst_in), .push(tx_push_c), .din(tx_din_c), .pop(tx_pop_c),
        .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk(clk_in), .rst(rst_in), .push(rx_push_c), .din(rx_data), .pop(rx_pop_ok_c),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Halt sequencing: the 0x00 terminator is retried until the TX FIFO has room
    always_comb begin
        state_nxt     = state;
        zero_pend_nxt = zero_pend;
        finished_nxt  = program_finished;
        tx_push_c     = 1'b0;
        tx_din_c      = bus.cpu_dout;
        case (state)
            RUN: begin
                if (uart_wr_c) begin
                    tx_push_c = tx_space_c;
                end else if (clk_wr_c) begin
                    tx_din_c      = 8'h00;
                    tx_push_c     = tx_space_c;
                    zero_pend_nxt = !tx_space_c;
                    state_nxt     = HALT_PENDING;
                end
            end
            HALT_PENDING: begin
                if (zero_pend) begin
                    tx_din_c      = 8'h00;
                    tx_push_c     = tx_space_c;
                    zero_pend_nxt = !tx_space_c;
                end else if (tx_pop_c && (tx_count == TX_CW'(1))) begin
                    state_nxt    = HALTED;
                    finished_nxt = 1'b1;
                end
            end
            HALTED:  finished_nxt = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= RUN;
            zero_pend        <= 1'b0;
            program_finished <= 1'b0;
        end else begin
            state            <= state_nxt;
            zero_pend        <= zero_pend_nxt;
            program_finished <= finished_nxt;
        end
    end

`ifdef MEM_IO_STATS_EN
    logic [31:0] sent_cnt, sent_snap, drop_cnt;
    logic        tx_drop_c, rx_drop_c;

    assign tx_drop_c = uart_wr_c && (state == RUN) && !tx_space_c;
    assign rx_drop_c = rx_valid && !rx_push_c;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sent_cnt  <= '0;
            sent_snap <= '0;
            drop_cnt  <= '0;
        end else begin
            sent_cnt <= sent_cnt + 32'(tx_pop_c);
            drop_cnt <= drop_cnt + 32'(tx_drop_c) + 32'(rx_drop_c);
            if (io_rd && (bus.mem_a == IO_STAT_SENT)) sent_snap <= sent_cnt;
        end
    end
`endif

    // I/O read mux; byte 0 of a counter reads live, upper bytes read the snapshot
    always_comb begin
        io_rdata_c = 8'h00;
        if (bus.mem_a == IO_UART) begin
            io_rdata_c = (rx_count != '0) ? rx_head : 8'h00;
        end else if (bus.mem_a[17:2] == IO_CLK[17:2]) begin
            io_rdata_c = (bus.mem_a[1:0] == 2'd0) ? cycle_cnt[7:0]
                                                  : byte_sel(snapshot, bus.mem_a[1:0]);
        end
`ifdef MEM_IO_STATS_EN
        else if (bus.mem_a[17:2] == IO_STAT_SENT[17:2]) begin
            io_rdata_c = (bus.mem_a[1:0] == 2'd0) ? sent_cnt[7:0]
                                                  : byte_sel(sent_snap, bus.mem_a[1:0]);
        end else if (bus.mem_a[17:2] == IO_STAT_DROP[17:2]) begin
            io_rdata_c = byte_sel(drop_cnt, bus.mem_a[1:0]);
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (ram_wr) ram[ram_idx] <= bus.cpu_dout;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.cpu_din        <= 8'h00;
            bus.io_buffer_full <= 1'b0;
            cycle_cnt          <= '0;
            snapshot           <= '0;
        end else begin
            cycle_cnt          <= cycle_cnt + 32'd1;
            bus.io_buffer_full <= (32'(tx_cnt_nxt) + FULL_MARGIN) >= TX_FIFO_DEPTH;
            if (io_rd && (bus.mem_a == IO_CLK)) snapshot <= cycle_cnt;
            if (!bus.mem_wr) bus.cpu_din <= is_io ? io_rdata_c : ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: table-driven bus vectors plus hand-written multi-cycle sequences.
module tb_mem_io_responder;
    import mem_io_pkg::*;

    typedef struct {
        logic [17:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    logic       clk_in, rst_in;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, program_finished;

    int         tests, fails, cyc;
    logic [7:0] txq [$];
    vec_t       vecs [$];

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .program_finished(program_finished)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Record every TX handshake, sampled mid-cycle
    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_op(input logic [17:0] a, input logic wr, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.cpu_dout = d;
        tick();
        bus.mem_a    = 18'h0;
        bus.mem_wr   = 1'b0;
        bus.cpu_dout = 8'h00;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        cyc    = 0;
    endtask

    task automatic fill_tx(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) bus_op(IO_UART, 1'b1, 8'(32'(base) + k));
    endtask

    task automatic wait_finished(input int budget);
        for (int k = 0; k < budget && !program_finished; k++) tick();
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rst_in = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        bus.mem_a = 18'h0; bus.mem_wr = 1'b0; bus.cpu_dout = 8'h00;

        // Reset values while reset is held
        tick();
        check("rst_cpu_din", 32'(bus.cpu_din), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_io_full", 32'(bus.io_buffer_full), 32'h0);
        check("rst_finished", 32'(program_finished), 32'h0);
        do_reset();

        vecs.push_back('{18'h00010, 1'b1, 8'hA5, 1'b0, 8'h00, "ram_wr_10"});
        vecs.push_back('{18'h00010, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_rd_10"});
        vecs.push_back('{18'h1FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, "ram_wr_top"});
        vecs.push_back('{18'h1FFFF, 1'b0, 8'h00, 1'b1, 8'h3C, "ram_rd_top"});
        vecs.push_back('{18'h00010, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_rd_10_again"});
        vecs.push_back('{18'h0FFFF, 1'b1, 8'h5E, 1'b0, 8'h00, "ram_wr_ffff"});
        vecs.push_back('{18'h0FFFF, 1'b0, 8'h00, 1'b1, 8'h5E, "ram_rd_ffff"});
        vecs.push_back('{18'h20010, 1'b1, 8'hC3, 1'b0, 8'h00, "ram_wr_alias"});
        vecs.push_back('{18'h00010, 1'b0, 8'h00, 1'b1, 8'hC3, "ram_rd_alias"});
        vecs.push_back('{18'h30000, 1'b0, 8'h00, 1'b1, 8'h00, "rx_empty_rd"});
        vecs.push_back('{18'h30003, 1'b0, 8'h00, 1'b1, 8'h00, "io_unmapped_3"});
        vecs.push_back('{18'h32000, 1'b0, 8'h00, 1'b1, 8'h00, "io_unmapped_2000"});
        vecs.push_back('{18'h30010, 1'b1, 8'h99, 1'b0, 8'h00, "io_wr_unmapped"});
        vecs.push_back('{18'h1FFFF, 1'b0, 8'h00, 1'b1, 8'h3C, "ram_rd_top_again"});
`ifndef MEM_IO_STATS_EN
        vecs.push_back('{18'h30008, 1'b0, 8'h00, 1'b1, 8'h00, "stat_sent_off"});
        vecs.push_back('{18'h3000C, 1'b0, 8'h00, 1'b1, 8'h00, "stat_drop_off"});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            bus_op(vecs[i].a, vecs[i].wr, vecs[i].d);
            if (vecs[i].chk) check(vecs[i].name, 32'(bus.cpu_din), 32'(vecs[i].exp));
        end
        idle(2);
        check("io_wr_unmapped_no_tx", 32'(txq.size()), 32'd0);

        // RX: two bytes queued, three pops; then push+pop on an empty FIFO
        rx_data = 8'h11; rx_valid = 1'b1; tick();
        rx_data = 8'h22; tick();
        rx_valid = 1'b0;
        bus_op(IO_UART, 1'b0, 8'h00); check("rx_pop_1", 32'(bus.cpu_din), 32'h11);
        bus_op(IO_UART, 1'b0, 8'h00); check("rx_pop_2", 32'(bus.cpu_din), 32'h22);
        bus_op(IO_UART, 1'b0, 8'h00); check("rx_pop_empty", 32'(bus.cpu_din), 32'h00);
        rx_data = 8'h33; rx_valid = 1'b1;
        bus_op(IO_UART, 1'b0, 8'h00);
        rx_valid = 1'b0;
        check("rx_pushpop_empty", 32'(bus.cpu_din), 32'h00);
        bus_op(IO_UART, 1'b0, 8'h00); check("rx_pushpop_kept", 32'(bus.cpu_din), 32'h33);

        // TX: zero writes to the UART register are filtered
        txq.delete();
        bus_op(IO_UART, 1'b1, 8'h41);
        bus_op(IO_UART, 1'b1, 8'h00);
        bus_op(IO_UART, 1'b1, 8'h42);
        idle(5);
        check("tx_filter_count", 32'(txq.size()), 32'd2);
        check("tx_filter_b0", 32'(txq[0]), 32'h41);
        check("tx_filter_b1", 32'(txq[1]), 32'h42);

        // TX back-pressure: near-full after 14, drop on the 17th, drain 16
        tx_ready = 1'b0;
        txq.delete();
        for (int i = 1; i <= 17; i++) begin
            bus_op(IO_UART, 1'b1, 8'(32'h50 + i));
            if (i == 13) check("io_full_13", 32'(bus.io_buffer_full), 32'h0);
            if (i == 14) check("io_full_14", 32'(bus.io_buffer_full), 32'h1);
        end
        check("io_full_17", 32'(bus.io_buffer_full), 32'h1);
        check("tx_head_full", 32'(tx_data), 32'h51);
        tx_ready = 1'b1;
        idle(30);
        check("tx_drain_count", 32'(txq.size()), 32'd16);
        check("tx_drain_first", 32'(txq[0]), 32'h51);
        check("tx_drain_last", 32'(txq[15]), 32'h60);
        check("io_full_cleared", 32'(bus.io_buffer_full), 32'h0);

        // Cycle counter: counter equals cycles elapsed since reset release
        do_reset();
        while (cyc < 100) tick();
        bus_op(IO_CLK, 1'b0, 8'h00);          check("clk_b0", 32'(bus.cpu_din), 32'h64);
        bus_op(IO_CLK + 18'd1, 1'b0, 8'h00);  check("clk_b1", 32'(bus.cpu_din), 32'h00);
        bus_op(IO_CLK + 18'd2, 1'b0, 8'h00);  check("clk_b2", 32'(bus.cpu_din), 32'h00);
        bus_op(IO_CLK + 18'd3, 1'b0, 8'h00);  check("clk_b3", 32'(bus.cpu_din), 32'h00);
        while (cyc < 511) tick();
        bus_op(IO_CLK, 1'b0, 8'h00);          check("clk511_b0", 32'(bus.cpu_din), 32'hFF);
        bus_op(IO_CLK + 18'd1, 1'b0, 8'h00);  check("clk511_b1_snap", 32'(bus.cpu_din), 32'h01);
        bus_op(IO_CLK + 18'd2, 1'b0, 8'h00);  check("clk511_b2", 32'(bus.cpu_din), 32'h00);

        // Halt with two bytes still queued
        tx_ready = 1'b0;
        txq.delete();
        bus_op(IO_UART, 1'b1, 8'h61);
        bus_op(IO_UART, 1'b1, 8'h62);
        bus_op(IO_CLK, 1'b1, 8'h5A);
        check("halt_not_yet", 32'(program_finished), 32'h0);
        tx_ready = 1'b1;
        wait_finished(40);
        check("halt_finished", 32'(program_finished), 32'h1);
        check("halt_tx_count_at_rise", 32'(txq.size()), 32'd3);
        check("halt_b0", 32'(txq[0]), 32'h61);
        check("halt_b1", 32'(txq[1]), 32'h62);
        check("halt_b2_zero", 32'(txq[2]), 32'h00);
        bus_op(IO_UART, 1'b1, 8'h77);
        idle(3);
        check("halted_wr_ignored", 32'(txq.size()), 32'd3);
        check("halted_tx_idle", 32'(tx_valid), 32'h0);
        check("halted_sticky", 32'(program_finished), 32'h1);
        bus_op(18'h00100, 1'b1, 8'hE7);
        bus_op(18'h00100, 1'b0, 8'h00);
        check("halted_ram_rd", 32'(bus.cpu_din), 32'hE7);

        // Halt while TX is full: terminator retried, later UART write ignored
        do_reset();
        check("reset_clears_finished", 32'(program_finished), 32'h0);
        tx_ready = 1'b0;
        txq.delete();
        fill_tx(16, 8'h80);
        check("full16_io_full", 32'(bus.io_buffer_full), 32'h1);
        bus_op(IO_CLK, 1'b1, 8'h00);
        bus_op(IO_UART, 1'b1, 8'h99);
        tx_ready = 1'b1;
        wait_finished(60);
        check("retry_finished", 32'(program_finished), 32'h1);
        check("retry_count", 32'(txq.size()), 32'd17);
        check("retry_first", 32'(txq[0]), 32'h80);
        check("retry_last_data", 32'(txq[15]), 32'h8F);
        check("retry_zero", 32'(txq[16]), 32'h00);

        // Asynchronous reset in the middle of HALT_PENDING
        do_reset();
        tx_ready = 1'b0;
        txq.delete();
        fill_tx(16, 8'hA0);
        bus_op(IO_CLK, 1'b1, 8'h00);
        check("pre_rst_io_full", 32'(bus.io_buffer_full), 32'h1);
        check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("async_rst_io_full", 32'(bus.io_buffer_full), 32'h0);
        check("async_rst_finished", 32'(program_finished), 32'h0);
        check("async_rst_cpu_din", 32'(bus.cpu_din), 32'h00);
        tick();
        rst_in = 1'b0;
        cyc = 0;
        bus_op(IO_UART, 1'b1, 8'h33);
        check("post_rst_tx_valid", 32'(tx_valid), 32'h1);
        check("post_rst_tx_data", 32'(tx_data), 32'h33);
        tx_ready = 1'b1;
        bus_op(18'h00100, 1'b0, 8'h00);
        check("ram_survives_reset", 32'(bus.cpu_din), 32'hE7);
        idle(3);
        check("post_rst_tx_sent", 32'(txq.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
